adc_spi_scheduler: RTL
======================

# adc_spi_scheduler

Round-robin sampling controller for the 10-bit serial ADC link used by the infrared/electromagnet sensing path. It shares one SPI ADC between four requesters and generates the full frame: chip select, serial clock and a 4-bit channel command. It captures the null bit and 10 data bits MSB-first, then returns each result tagged with its channel. It sits between the sensor-processing logic (requesters) and the ADC pins.

## Interface
Parameters:
- CLK_DIV, 8, CLK cycles per SCLK half-period; legal values are ≥2.
- CS_IDLE, 2, minimum number of SCLK periods that CSn stays high between frames; legal values are ≥1.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- Enable  in  1  scheduler enable; gates new grants only.
- Req  in  4  level request; bit n requests ADC channel n.
- Grant  out  4  one-hot, one-cycle pulse; marks the requester whose frame has just started.
- Busy  out  1  high in every state except IDLE.
- DataOut  out  10  last captured sample.
- DataCh  out  2  channel of DataOut.
- DataValid  out  1  one-cycle pulse; DataOut and DataCh are updated on the same edge.
- ErrNull  out  1  valid with DataValid; high when the captured null bit was 1.
- SCLK  out  1  ADC serial clock; idles low.
- CSn  out  1  ADC chip select, active low.
- MOSI  out  1  command to the ADC.
- MISO  in  1  ADC serial data.

## Operation
- States: IDLE → CMD (4 SCLK periods) → NULL (1 period) → DATA (10 periods) → GAP (CS_IDLE periods) → IDLE.
- Arbitration happens in IDLE only, and only when Enable=1 and Req≠0.
  - The winner is the first set bit of Req, searching circularly from the pointer Ptr.
  - Ptr resets to 0. On each grant, Ptr ← winner+1 (mod 4).
- Grant is registered:
  - Grant[winner] pulses on the edge that leaves IDLE.
  - The winning channel is latched into an internal register.
  - Req is ignored outside IDLE.
  - A requester that holds Req high is served again on its next round-robin turn.
- SCLK period is 2·CLK_DIV cycles: the low half comes first, then the high half. SCLK toggles only while CSn=0.
- MOSI changes only on the edge that starts a period (SCLK low). Per period:
  - CMD bits: 1 (start), 1 (single-ended), Ch[1], Ch[0].
  - NULL, DATA and GAP: 0.
- MISO is sampled on the CLK edge that drives SCLK 0→1.
  - The NULL sample is stored as the null flag.
  - DATA samples are shifted in MSB first.
- On the edge that ends the last DATA period, all of the following happen together:
  - CSn goes to 1.
  - DataOut ← shift register and DataCh ← latched channel.
  - ErrNull ← null flag.
  - DataValid pulses.
- Enable=0 never aborts a frame. The frame in progress completes and returns its data; no new Grant is issued until Enable=1.
- All counters (half-period, bit, gap) are sized for their parameter maxima and wrap only by explicit reload.

## Timing
- Reset values:
  - SCLK=0, CSn=1, MOSI=0, Grant=0, Busy=0.
  - DataOut=0, DataCh=0, DataValid=0, ErrNull=0.
  - Ptr=0, state IDLE.
- RST asserted mid-frame forces CSn=1 and SCLK=0 immediately (asynchronously). The partial sample is discarded: no DataValid.
- Let T be the first cycle in which Grant is high. Then:
  - CSn is low in cycles T … T+30·CLK_DIV−1.
  - SCLK first rises at T+CLK_DIV.
  - DataValid is high in cycle T+30·CLK_DIV; with defaults, T+240.
- GAP holds CSn high for 2·CS_IDLE·CLK_DIV cycles, then the state is IDLE.
- Minimum Grant-to-Grant spacing is 30·CLK_DIV + 2·CS_IDLE·CLK_DIV + 1 cycles; with defaults, 273.
- Busy is high from T through the last GAP cycle.
- Req rising in the same cycle that GAP exits is seen in the first IDLE cycle.

## Test plan
- Reset: hold RST for 5 cycles, then release with Req=0 → every output stays at its reset value for 500 cycles and SCLK never toggles.
- Single request: Req=4'b0100; ADC model returns null=0, data=10'h2A5 → Grant=4'b0100; MOSI shows 1,1,1,0; DataValid 240 cycles after Grant with DataOut=10'h2A5, DataCh=2, ErrNull=0; exactly 15 SCLK rising edges.
- Round robin: Req=4'b1111 held → Grants occur in order 0,1,2,3,0, spaced 273 cycles apart. Then Req=4'b1001 after a grant to 0 → next grant is 3, then 0.
- Extremes and null error: data 10'h3FF with null=1 → DataOut=10'h3FF, ErrNull=1. Then data 10'h000 with null=0 → DataOut=0, ErrNull=0.
- Reset mid-frame: assert RST during DATA bit 5 → CSn=1 and SCLK=0 before the next CLK edge; no DataValid. After release, Req=4'b1111 → first grant goes to 0.
- Enable drop: Enable 1→0 during CMD with Req=4'b0010 held → the current frame completes with DataValid and no further Grant. Enable back to 1 → next Grant comes from IDLE with the pointer unchanged.

Source files
------------

// File: rtl/adc_spi_scheduler.sv
// Round-robin scheduler that shares one 10-bit serial ADC between four requesters.
// Each frame drives CSn, SCLK and a 4-bit channel command, then captures the null bit and 10 data bits.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | CSn high, waiting for Enable and a request; arbitration here
// ST_CMD  | 4 SCLK periods shifting out start, single-ended, Ch[1], Ch[0]
// ST_NULL | 1 SCLK period capturing the ADC null bit
// ST_DATA | 10 SCLK periods shifting in the sample MSB first
// ST_GAP  | CSn held high for CS_IDLE SCLK periods before the next grant
module adc_spi_scheduler #(
  parameter int CLK_DIV = 8,
  parameter int CS_IDLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Enable,
  input  logic [3:0] Req,
  output logic [3:0] Grant,
  output logic       Busy,
  output logic [9:0] DataOut,
  output logic [1:0] DataCh,
  output logic       DataValid,
  output logic       ErrNull,
  output logic       SCLK,
  output logic       CSn,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int GAP_CYC = 2 * CS_IDLE * CLK_DIV;
  localparam int HW      = $clog2(CLK_DIV);
  localparam int GW      = $clog2(GAP_CYC);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_NULL, ST_DATA, ST_GAP} state_t;

  state_t          state;
  logic [HW-1:0]   hcnt;
  logic [3:0]      bcnt;
  logic [GW-1:0]   gcnt;
  logic [1:0]      ptr;
  logic [1:0]      ch;
  logic            null_flag;
  logic [9:0]      shreg;
  logic [3:0]      cmd;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            win_ok;

  assign cmd = {2'b11, ch};

  // first set request bit, searching circularly from ptr
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!win_ok && Req[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      hcnt      <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      ptr       <= '0;
      ch        <= '0;
      null_flag <= 1'b0;
      shreg     <= '0;
      Grant     <= '0;
      Busy      <= 1'b0;
      DataOut   <= '0;
      DataCh    <= '0;
      DataValid <= 1'b0;
      ErrNull   <= 1'b0;
      SCLK      <= 1'b0;
      CSn       <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      Grant     <= '0;
      DataValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Enable && win_ok) begin
            state <= ST_CMD;
            Grant <= 4'b0001 << win;
            ch    <= win;
            ptr   <= win + 2'd1;
            Busy  <= 1'b1;
            CSn   <= 1'b0;
            MOSI  <= 1'b1;
            hcnt  <= HW'(CLK_DIV - 1);
            bcnt  <= 4'd3;
          end
        end
        ST_CMD, ST_NULL, ST_DATA: begin
          if (hcnt != '0) begin
            hcnt <= hcnt - HW'(1);
          end else begin
            hcnt <= HW'(CLK_DIV - 1);
            if (!SCLK) begin
              // rising SCLK: the ADC output is stable mid-period
              SCLK <= 1'b1;
              if (state == ST_NULL) null_flag <= MISO;
              if (state == ST_DATA) shreg <= {shreg[8:0], MISO};
            end else begin
              SCLK <= 1'b0;
              if (bcnt != 4'd0) begin
                bcnt <= bcnt - 4'd1;
                MOSI <= (state == ST_CMD) ? cmd[2'(bcnt - 4'd1)] : 1'b0;
              end else begin
                case (state)
                  ST_CMD: begin
                    state <= ST_NULL;
                    MOSI  <= 1'b0;
                  end
                  ST_NULL: begin
                    state <= ST_DATA;
                    bcnt  <= 4'd9;
                  end
                  default: begin
                    state     <= ST_GAP;
                    CSn       <= 1'b1;
                    DataOut   <= shreg;
                    DataCh    <= ch;
                    ErrNull   <= null_flag;
                    DataValid <= 1'b1;
                    gcnt      <= GW'(GAP_CYC - 1);
                  end
                endcase
              end
            end
          end
        end
        ST_GAP: begin
          if (gcnt == '0) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
